lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the RV32 core datapath and the data-memory bus.
- Takes a memory op from decode/execute: we, data_size (funct3), ALU address and rs2 data.
- Drives a req/gnt/rvalid bus, stalls the core until the access completes, and returns aligned, sign- or zero-extended load data for register writeback.

Parameters:
- TIMEOUT, 16: max cycles in REQ or WAIT before abort with error; 0 disables the timeout.
- AW, 32: address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  memory op present this cycle
- we_i  in  1  1 = store, 0 = load
- data_size_i  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  AW  byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  freeze PC and pipeline
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data, valid when done_o=1
- err_o  out  1  access fault, valid when done_o=1
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read word

Behaviour:
- Reset: state IDLE; mem_req_o, done_o, err_o = 0; rdata_o = 0; timeout counter = 0; captured op registers = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On valid_i, capture we, size, addr and wdata.
  - Illegal size (011, 110, 111), or misaligned access (see Optional Feature): go to DONE with err set; no bus activity.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1; address, we, be and wdata held stable from the captured registers until gnt.
  - On mem_gnt_i: store goes to DONE; load goes to WAIT.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i: capture the extracted load data, go to DONE.
  - rvalid is never accepted in the same cycle as gnt; earliest is the cycle after gnt.
- DONE: done_o=1 for exactly one cycle, stall_o=0, then IDLE. valid_i is ignored in DONE.
- stall_o = (IDLE & valid_i) | REQ | WAIT. Combinational, so the core freezes in the issue cycle.
- Latency (valid to done):
  - Store with gnt on first REQ cycle: 2 cycles.
  - Load with gnt then rvalid one cycle later: 3 cycles.
  - Error: 1 cycle.
- Byte enables:
  - B/BU: 0001 << addr[1:0].
  - H/HU: 0011 << {addr[1],1'b0}.
  - W: 1111.
- Write data:
  - B: byte replicated x4.
  - H: half replicated x2.
  - W: unchanged.
- Load extraction:
  - Word shifted right by {addr[1:0],3'b000}.
  - B/H: sign-extended from bit 7/15.
  - BU/HU: zero-extended.
  - W: unchanged.
- Timeout:
  - Counter cleared on entry to REQ and on REQ to WAIT; increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: drop mem_req_o, go to DONE with err=1 and rdata_o=0.
- rdata_o holds its last value outside DONE. err_o is 0 outside DONE.
- rst mid-operation: IDLE on the next edge; mem_req_o low from that edge. A stale rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned access (H with addr[0]=1, W with addr[1:0]!=0) goes IDLE to DONE with err_o=1; no bus request.
- Undefined: the address is aligned down to the natural boundary (low bits forced to 0), the access proceeds normally, and err_o=0.

Decomposition:
- Shared package riscv_pkg:
  - Load/store funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - Typedef lsu_state_e {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module, lsu_align: computes be, replicated wdata and extended rdata from size and addr[1:0]. The FSM and timeout stay in lsu_ctrl.

Test Plan:
- LW, addr 0x100, gnt cycle 1, rvalid 0xDEADBEEF next cycle -> mem_be_o=1111, done on cycle 3, rdata_o=0xDEADBEEF, err_o=0.
- LB, addr 0x103, rdata 0x80FF_1234 -> rdata_o=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH, addr 0x102, wdata 0x0000ABCD, gnt delayed 3 cycles -> req held 4 cycles with stable outputs, be=1100, mem_wdata_o=0xABCDABCD, stall_o high until done.
- LW, addr 0x101:
  - With LSU_MISALIGN_TRAP_EN: done next cycle, err_o=1, no mem_req_o.
  - Without: mem_addr_o=0x100, normal completion.
- TIMEOUT=4, load, gnt never asserted -> mem_req_o drops after 4 cycles, done_o=1, err_o=1, rdata_o=0. data_size 011 -> err in 1 cycle.
- rst asserted in WAIT, rvalid arrives in following cycle -> IDLE, done_o never pulses, rdata_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 load/store definitions. This package holds the
//               funct3 size codes, the load/store sequencer state type and a
//               helper that spots reserved size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes. They share encodings with the signed loads.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Load/store sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Reserved size codes: these never reach the bus
    function automatic logic size_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the load/store unit. It
//               generates byte enables, replicates store data across the byte
//               lanes, and right-aligns and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Move the addressed byte/half down to bit 0 before extension
    assign w_shifted = i_rword >> {i_off, 3'b000};

    // Byte enables and lane-replicated store data. Only size[1:0] matters here,
    // so BU/HU codes behave like B/H.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Sign or zero extension of the aligned load data
    always_comb begin
        o_rdata = w_shifted;
        case (i_size)
            F3_LB:   o_rdata = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_rdata = {24'h000000, w_shifted[7:0]};
            F3_LHU:  o_rdata = {16'h0000,   w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Multi-cycle RV32 load/store sequencer. It issues one memory op
//               on a req/gnt/rvalid bus, stalls the core while the op is in
//               flight, and returns extended load data with a done pulse.
// Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses
//               complete immediately with err_o. When undefined, the address is
//               aligned down to the natural boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          we_i,
    input  logic [2:0]    data_size_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          stall_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i
);

    // The counter must be able to hold TIMEOUT itself
    localparam int                 c_cnt_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    lsu_state_e         r_state;
    lsu_state_e         w_next;

    logic               r_we;
    logic [2:0]         r_size;
    logic [AW-1:0]      r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_illegal;
    logic               w_bad;
    logic               w_timeout;
    logic [AW-1:0]      w_addr_cap;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rdata_ext;

    // Classify the incoming op and choose the address that will be captured
    always_comb begin
        w_illegal  = size_illegal(data_size_i);
        w_addr_cap = addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
        w_bad = w_illegal
              | ((data_size_i[1:0] == 2'b01) & addr_i[0])
              | ((data_size_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
`else
        w_bad = w_illegal;
        case (data_size_i[1:0])
            2'b01:   w_addr_cap[0]   = 1'b0;
            2'b10:   w_addr_cap[1:0] = 2'b00;
            default: ;
        endcase
`endif
    end

    // A zero TIMEOUT disables the abort completely
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_timeout);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and bus/core handshake outputs
    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        mem_req_o = 1'b0;
        case (r_state)
            IDLE: begin
                // Stall combinationally so the core holds the op in its issue cycle
                stall_o = valid_i;
                if (valid_i) begin
                    w_next = w_bad ? DONE : REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (w_timeout) begin
                    w_next = DONE;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) begin
                        w_next = r_we ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (w_timeout || mem_rvalid_i) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the op on issue, then record its outcome (error or load data)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_we    <= we_i;
                        r_size  <= data_size_i;
                        r_addr  <= w_addr_cap;
                        r_wdata <= wdata_i;
                        r_err   <= w_bad;
                        if (w_bad) begin
                            r_rdata <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end
                end
                WAIT: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end else if (mem_rvalid_i) begin
                        r_rdata <= w_rdata_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout counter. It restarts for each bus phase and counts the cycles spent in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_cnt <= '0;
                    end
                end
                REQ: begin
                    if (!w_timeout && mem_gnt_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    lsu_align u_align (
        .i_size  (r_size),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rword (mem_rdata_i),
        .o_be    (w_be),
        .o_wdata (w_wdata_rep),
        .o_rdata (w_rdata_ext)
    );

    // Bus fields come straight from the captured op, so they stay stable until gnt
    assign mem_we_o    = r_we;
    assign mem_addr_o  = {r_addr[AW-1:2], 2'b00};
    assign mem_be_o    = w_be;
    assign mem_wdata_o = w_wdata_rep;

    assign rdata_o = r_rdata;
    assign err_o   = (r_state == DONE) & r_err;

endmodule
`default_nettype wire
